// File: rtl/seg7_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the 7-segment scan driver.
//   state_e    : scan FSM states (IDLE, GAP, DRIVE)
//   SEG_OFF    : segment bus value with every segment dark (active-low)
//   AN_OFF     : anode mask with every digit disabled (active-low)
//   NUM_DIGITS : number of multiplexed digits
//   onehot_n() : active-low anode mask selecting a single digit
// -----------------------------------------------------------------------------
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GAP   = 2'd1,
      DRIVE = 2'd2
   } state_e;

   localparam logic [7:0] SEG_OFF    = 8'hFF;
   localparam logic [3:0] AN_OFF     = 4'hF;
   localparam int         NUM_DIGITS = 4;

   function automatic logic [3:0] onehot_n(input logic [1:0] idx);
      logic [3:0] mask;
      mask      = AN_OFF;
      mask[idx] = 1'b0;
      return mask;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the pattern-load handshake, control inputs and display outputs of
// the scan driver.
//   enable            : 1 = scan active, 0 = display dark
//   seg3_i..seg0_i    : active-low digit patterns (bit 7 = dp), seg3 leftmost
//   load_req/load_ack : request a shadow update / 1-cycle load acknowledge
//   blink_en          : per-digit blink enable
//   an_n, seg_n       : active-low anode enables and shared segment bus
//   frame_tick        : 1-cycle pulse after every frame boundary
// master = pattern source / display consumer, slave = scan driver.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if;

   logic       enable;
   logic [7:0] seg3_i;
   logic [7:0] seg2_i;
   logic [7:0] seg1_i;
   logic [7:0] seg0_i;
   logic       load_req;
   logic       load_ack;
   logic [3:0] blink_en;
   logic [3:0] an_n;
   logic [7:0] seg_n;
   logic       frame_tick;

   modport master (
      output enable, seg3_i, seg2_i, seg1_i, seg0_i, load_req, blink_en,
      input  load_ack, an_n, seg_n, frame_tick
   );

   modport slave (
      input  enable, seg3_i, seg2_i, seg1_i, seg0_i, load_req, blink_en,
      output load_ack, an_n, seg_n, frame_tick
   );

endinterface

// File: rtl/seg7_scan_driver_slot_counter.sv
// -----------------------------------------------------------------------------
// seg7_slot_counter
// Digit-slot timer. Counts 0..REFRESH_DIV-1 while run is high and wraps;
// holds at 0 while run is low.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : count enable; low clears the counter
//   gap_end    : counter is on the last dead-time cycle
//   slot_end   : counter is on the last cycle of the slot
//   in_gap     : counter is inside the dead-time window
// -----------------------------------------------------------------------------
module seg7_slot_counter #(
   parameter int REFRESH_DIV = 100000,
   parameter int DEADTIME    = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic gap_end,
   output logic slot_end,
   output logic in_gap
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!run) begin
         cnt_d = '0;
      end else if (slot_end) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign slot_end = (cnt_q == CW'(REFRESH_DIV - 1));
   assign gap_end  = (cnt_q == CW'(DEADTIME - 1));
   assign in_gap   = (cnt_q <  CW'(DEADTIME));

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexes four pre-encoded active-low digit patterns onto a shared
// segment bus with per-digit active-low anode enables. Patterns are copied
// into shadow registers only at frame boundaries so a frame never tears.
// Each digit slot starts with a dead-time window (all anodes off) to avoid
// ghosting; digits can blink with a half-period of BLINK_FRAMES frames.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : seg7_scan_driver_if slave (enable, patterns, load handshake,
//           blink_en, an_n, seg_n, frame_tick)
// -----------------------------------------------------------------------------
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int DEADTIME     = 64,
   parameter int BLINK_FRAMES = 250
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seg7_scan_driver_if.slave    bus
);

   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   state_e     state_q,  state_d;
   logic [1:0] idx_q,    idx_d;
   logic [7:0] shadow_q [NUM_DIGITS];
   logic [7:0] shadow_d [NUM_DIGITS];
   logic       pending_q, pending_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic       blink_phase_q, blink_phase_d;
   logic [3:0] an_n_q,   an_n_d;
   logic [7:0] seg_n_q,  seg_n_d;
   logic       load_ack_q, load_ack_d;
   logic       frame_tick_q, frame_tick_d;

   logic       gap_end;
   logic       slot_end;
   logic       in_gap;
   logic       slot_run;
   logic       boundary;
   logic       load_now;
   logic       drive_on;

   // The slot counter only runs while scanning; IDLE and disable hold it at 0
   // so every restart begins at the first dead-time cycle.
   assign slot_run = bus.enable && (state_q != IDLE);

   seg7_slot_counter #(
      .REFRESH_DIV (REFRESH_DIV),
      .DEADTIME    (DEADTIME)
   ) u_slot_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (slot_run),
      .gap_end  (gap_end),
      .slot_end (slot_end),
      .in_gap   (in_gap)
   );

   // A frame boundary is the last cycle of digit 3, or the restart from IDLE.
   // Disabling in the boundary cycle cancels it.
   assign boundary = bus.enable &&
                     ((state_q == IDLE) ||
                      ((state_q == DRIVE) && (idx_q == 2'd3) && slot_end));

   // A request arriving in the boundary cycle itself is honoured immediately.
   assign load_now = boundary && (pending_q || bus.load_req);

   assign drive_on = bus.enable && (state_q == DRIVE) && !in_gap;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (!bus.enable) begin
         state_d = IDLE;
         idx_d   = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = GAP;
               idx_d   = 2'd0;
            end
            GAP: begin
               if (gap_end) begin
                  state_d = DRIVE;
               end
            end
            DRIVE: begin
               if (slot_end) begin
                  state_d = GAP;
                  idx_d   = idx_q + 2'd1;
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = 2'd0;
            end
         endcase
      end
   end

   // Shadows, load handshake and blink bookkeeping
   always_comb begin
      shadow_d      = shadow_q;
      pending_d     = pending_q;
      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;

      if (load_now) begin
         shadow_d[3] = bus.seg3_i;
         shadow_d[2] = bus.seg2_i;
         shadow_d[1] = bus.seg1_i;
         shadow_d[0] = bus.seg0_i;
         pending_d   = 1'b0;
      end else if (bus.load_req) begin
         pending_d   = 1'b1;
      end

      // Blink phase survives a disable; only the frame count restarts.
      if (!bus.enable) begin
         frame_cnt_d = '0;
      end else if (boundary) begin
         if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt_d   = '0;
            blink_phase_d = !blink_phase_q;
         end else begin
            frame_cnt_d   = frame_cnt_q + FW'(1);
         end
      end
   end

   // Registered outputs: they follow the current state by one cycle, so the
   // anode and segment buses always switch on the same clock edge.
   always_comb begin
      an_n_d       = AN_OFF;
      seg_n_d      = SEG_OFF;
      load_ack_d   = load_now;
      frame_tick_d = boundary;
      if (drive_on) begin
         seg_n_d = shadow_q[idx_q];
         if (!(bus.blink_en[idx_q] && blink_phase_q)) begin
            an_n_d = onehot_n(idx_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         idx_q         <= 2'd0;
         for (int k = 0; k < NUM_DIGITS; k++) begin
            shadow_q[k] <= SEG_OFF;
         end
         pending_q     <= 1'b0;
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         an_n_q        <= AN_OFF;
         seg_n_q       <= SEG_OFF;
         load_ack_q    <= 1'b0;
         frame_tick_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         pending_q     <= pending_d;
         frame_cnt_q   <= frame_cnt_d;
         blink_phase_q <= blink_phase_d;
         an_n_q        <= an_n_d;
         seg_n_q       <= seg_n_d;
         load_ack_q    <= load_ack_d;
         frame_tick_q  <= frame_tick_d;
      end
   end

   assign bus.an_n       = an_n_q;
   assign bus.seg_n      = seg_n_q;
   assign bus.load_ack   = load_ack_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Scoreboard bench for seg7_scan_driver (REFRESH_DIV=8, DEADTIME=2,
// BLINK_FRAMES=2). A reference model tracks the position inside the frame
// arithmetically and pushes the expected outputs after every clock edge; a
// separate monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

   localparam int R  = 8;
   localparam int D  = 2;
   localparam int BF = 2;
   localparam int FR = 4 * R;

   typedef struct {
      logic [3:0] an;
      logic [7:0] seg;
      logic       ack;
      logic       tick;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   seg7_scan_driver_if bus ();

   seg7_scan_driver #(
      .REFRESH_DIV  (R),
      .DEADTIME     (D),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   // reference model state
   logic       m_run;
   int         m_t;
   logic [7:0] m_sh [4];
   logic       m_pend;
   int         m_fc;
   logic       m_phase;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: frame position m_t counts cycles since the frame start.
   always @(posedge clk) begin : model
      exp_t e;
      logic bnd;
      int   dig;
      int   off;
      e.an  = 4'hF;
      e.seg = 8'hFF;
      e.ack = 1'b0;
      e.tick = 1'b0;
      if (!rst_n) begin
         m_run   = 1'b0;
         m_t     = 0;
         m_pend  = 1'b0;
         m_fc    = 0;
         m_phase = 1'b0;
         for (int k = 0; k < 4; k++) m_sh[k] = 8'hFF;
      end else begin
         bnd = bus.enable && (!m_run || (m_t == FR - 1));
         if (bus.enable && m_run) begin
            dig = m_t / R;
            off = m_t % R;
            if (off >= D) begin
               e.seg = m_sh[dig];
               if (!(bus.blink_en[dig] && m_phase)) e.an = ~(4'b0001 << dig);
            end
         end
         e.tick = bnd;
         e.ack  = bnd && (m_pend || bus.load_req);
         if (e.ack) begin
            m_sh[0] = bus.seg0_i;
            m_sh[1] = bus.seg1_i;
            m_sh[2] = bus.seg2_i;
            m_sh[3] = bus.seg3_i;
            m_pend  = 1'b0;
         end else if (bus.load_req) begin
            m_pend = 1'b1;
         end
         if (!bus.enable) begin
            m_fc = 0;
         end else if (bnd) begin
            if (m_fc == BF - 1) begin
               m_fc    = 0;
               m_phase = !m_phase;
            end else begin
               m_fc++;
            end
         end
         if (!bus.enable) begin
            m_run = 1'b0;
            m_t   = 0;
         end else if (!m_run) begin
            m_run = 1'b1;
            m_t   = 0;
         end else begin
            m_t = (m_t + 1) % FR;
         end
      end
      sb_q.push_back(e);
   end

   // Monitor: compares DUT outputs 1 time unit after each active edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
         end else begin
            e = sb_q.pop_front();
            chk("an_n",       32'(bus.an_n),       32'(e.an));
            chk("seg_n",      32'(bus.seg_n),      32'(e.seg));
            chk("load_ack",   32'(bus.load_ack),   32'(e.ack));
            chk("frame_tick", 32'(bus.frame_tick), 32'(e.tick));
         end
      end
   end

   task automatic wait_pos(input int want_dig, input int min_off, input string name);
      int i;
      i = 0;
      while (!(m_run && bus.enable && (want_dig < 0 || m_t / R == want_dig) &&
               (m_t % R >= min_off)) && i < 4 * FR) begin
         @(negedge clk);
         i++;
      end
      if (i >= 4 * FR) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_boundary();
      int i;
      i = 0;
      while (!(m_run && bus.enable && m_t == FR - 1) && i < 4 * FR) begin
         @(negedge clk);
         i++;
      end
      if (i >= 4 * FR) chk("boundary_timeout", 32'd0, 32'd1);
   endtask

   task automatic rand_segs();
      bus.seg3_i = 8'($urandom);
      bus.seg2_i = 8'($urandom);
      bus.seg1_i = 8'($urandom);
      bus.seg0_i = 8'($urandom);
   endtask

   initial begin : stim
      bus.enable   = 1'b0;
      bus.load_req = 1'b0;
      bus.blink_en = 4'b0000;
      bus.seg3_i   = 8'hFF;
      bus.seg2_i   = 8'hFF;
      bus.seg1_i   = 8'hFF;
      bus.seg0_i   = 8'hFF;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an_n",       32'(bus.an_n),       32'hF);
      chk("rst_seg_n",      32'(bus.seg_n),      32'hFF);
      chk("rst_load_ack",   32'(bus.load_ack),   32'h0);
      chk("rst_frame_tick", 32'(bus.frame_tick), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // basic scan with initial load on enable
      bus.seg3_i = 8'hC0;
      bus.seg2_i = 8'hF9;
      bus.seg1_i = 8'hA4;
      bus.seg0_i = 8'hB0;
      bus.enable   = 1'b1;
      bus.load_req = 1'b1;
      @(negedge clk);
      bus.load_req = 1'b0;
      repeat (2 * FR) @(negedge clk);

      // input change without request is invisible; mid-frame request waits
      wait_pos(1, D, "mid1");
      bus.seg1_i = 8'h99;
      repeat (FR) @(negedge clk);
      wait_pos(2, 0, "mid2");
      bus.load_req = 1'b1;
      @(negedge clk);
      bus.load_req = 1'b0;
      repeat (2 * FR) @(negedge clk);

      // request exactly in the boundary cycle
      wait_boundary();
      rand_segs();
      bus.load_req = 1'b1;
      @(negedge clk);
      bus.load_req = 1'b0;
      rand_segs();
      repeat (FR + FR / 2) @(negedge clk);

      // request held for three frames
      bus.load_req = 1'b1;
      for (int f = 0; f < 3; f++) begin
         rand_segs();
         repeat (FR) @(negedge clk);
      end
      bus.load_req = 1'b0;
      repeat (FR) @(negedge clk);

      // blink digit 2
      bus.blink_en = 4'b0100;
      repeat (8 * FR) @(negedge clk);
      bus.blink_en = 4'b0000;

      // disable during digit 2 drive, then restart
      wait_pos(2, D + 1, "dis");
      bus.enable = 1'b0;
      repeat (5) @(negedge clk);
      bus.enable = 1'b1;
      repeat (2 * FR) @(negedge clk);

      // randomized traffic
      for (int c = 0; c < 800; c++) begin
         bus.load_req = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) rand_segs();
         if ($urandom_range(0, 63) == 0) bus.blink_en = 4'($urandom);
         bus.enable = ($urandom_range(0, 63) != 0);
         @(negedge clk);
      end
      bus.load_req = 1'b0;
      bus.enable   = 1'b1;
      bus.blink_en = 4'b0000;
      repeat (FR) @(negedge clk);

      // asynchronous reset mid-drive with a pending load
      wait_pos(1, D + 1, "arst");
      rand_segs();
      bus.load_req = 1'b1;
      @(negedge clk);
      bus.load_req = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_an_n",       32'(bus.an_n),       32'hF);
      chk("arst_seg_n",      32'(bus.seg_n),      32'hFF);
      chk("arst_load_ack",   32'(bus.load_ack),   32'h0);
      chk("arst_frame_tick", 32'(bus.frame_tick), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3 * FR) @(negedge clk);

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
